// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {BOOT, REQ, BUF} fetch_state_t;

  localparam int NOP_INSTR  = 0;
  localparam int PC8_OFFSET = 8;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched word and its PC+8 while decode stalls.
module fetch_skid_buffer #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [BITS-1:0] instr_in,
  input  logic [BITS-1:0] pc8_in,
  output logic [BITS-1:0] instr,
  output logic [BITS-1:0] pc8,
  output logic            valid
);

  // Clear (redirect) beats push, push beats pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
      pc8   <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (push) begin
      instr <= instr_in;
      pc8   <= pc8_in;
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, redirect handling
// and a one-entry skid buffer for words fetched while decode is stalled.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              BITS     = 32,
  parameter logic [BITS-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            BranchTakenE,
  input  logic [BITS-1:0] BranchTargetE,
  input  logic            PCSrcW,
  input  logic [BITS-1:0] ResultW,
  output logic            ImemReq,
  output logic [BITS-1:0] ImemAddr,
  input  logic [BITS-1:0] ImemRData,
  input  logic            ImemReady,
  output logic [BITS-1:0] InstrD,
  output logic [BITS-1:0] PCPlus8D,
  output logic            ValidD
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [BITS-1:0] pc;
  logic [BITS-1:0] pc_next;
  logic [BITS-1:0] redirect_pc;
  logic            redirect;
  logic            fire;
  logic            keep_word;
  logic            push;
  logic            pop;
  logic [BITS-1:0] buf_instr;
  logic [BITS-1:0] buf_pc8;
  logic            buf_valid;

  assign redirect    = BranchTakenE | PCSrcW;
  assign redirect_pc = BranchTakenE ? BranchTargetE : ResultW;
  assign fire        = ImemReq & ImemReady;
  assign keep_word   = fire & ~redirect;
  assign push        = keep_word & StallD;
  assign pop         = (state == BUF) & buf_valid & ~StallD & ~redirect;
  assign ImemAddr    = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = REQ;
    end else begin
      case (state)
        BOOT:    state_next = REQ;
        REQ:     if (push) state_next = BUF;
        BUF:     if (!StallD) state_next = REQ;
        default: state_next = BOOT;
      endcase
    end
  end

  always_comb begin
    ImemReq = (state == REQ) & ~StallF;
  end

  // A redirect wins over both StallF and any word firing this cycle.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = redirect_pc;
    end else if (fire) begin
      pc_next = pc + BITS'(PC_INC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  fetch_skid_buffer #(.BITS(BITS)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .clear    (redirect),
    .instr_in (ImemRData),
    .pc8_in   (pc + BITS'(PC8_OFFSET)),
    .instr    (buf_instr),
    .pc8      (buf_pc8),
    .valid    (buf_valid)
  );

  // Flush beats stall; with nothing to load the register takes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= BITS'(NOP_INSTR);
      PCPlus8D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= BITS'(NOP_INSTR);
      PCPlus8D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      if (keep_word) begin
        InstrD   <= ImemRData;
        PCPlus8D <= pc + BITS'(PC8_OFFSET);
        ValidD   <= 1'b1;
      end else if (pop) begin
        InstrD   <= buf_instr;
        PCPlus8D <= buf_pc8;
        ValidD   <= 1'b1;
      end else begin
        InstrD   <= BITS'(NOP_INSTR);
        PCPlus8D <= '0;
        ValidD   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        StallF, StallD, FlushD;
  logic        BranchTakenE, PCSrcW;
  logic [31:0] BranchTargetE, ResultW;
  logic        ImemReq, ImemReady;
  logic [31:0] ImemAddr, ImemRData;
  logic [31:0] InstrD, PCPlus8D;
  logic        ValidD;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
    .PCSrcW(PCSrcW), .ResultW(ResultW),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemRData(ImemRData), .ImemReady(ImemReady),
    .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hE500_0000 ^ a;
  endfunction

  always_comb ImemRData = word_at(ImemAddr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    StallF = 0; StallD = 0; FlushD = 0;
    BranchTakenE = 0; BranchTargetE = 0; PCSrcW = 0; ResultW = 0;
    ImemReady = 1;
  endtask

  // Leaves the bench 1ns into the first REQ cycle with PCF at reset value.
  task automatic reset_dut;
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", ImemReq); end
    checks++; if (ImemAddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", ImemAddr); end
    checks++; if (InstrD !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0", InstrD); end
    checks++; if (PCPlus8D !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc8: got %h expected 0", PCPlus8D); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", ValidD); end
  endtask

  task automatic test_sequential;
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    @(negedge clk);
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("[TB] FAIL boot_idle: got %b expected 0", ImemReq); end
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      checks++; if (ImemReq !== 1'b1) begin errors++; $display("[TB] FAIL seq_req[%0d]: got %b expected 1", i, ImemReq); end
      checks++; if (ImemAddr !== 32'(4 * i)) begin errors++; $display("[TB] FAIL seq_addr[%0d]: got %h expected %h", i, ImemAddr, 32'(4 * i)); end
      if (i > 0) begin
        checks++; if (InstrD !== word_at(32'(4 * (i - 1)))) begin errors++; $display("[TB] FAIL seq_instr[%0d]: got %h expected %h", i, InstrD, word_at(32'(4 * (i - 1)))); end
        checks++; if (PCPlus8D !== 32'(4 * (i - 1) + 8)) begin errors++; $display("[TB] FAIL seq_pc8[%0d]: got %h expected %h", i, PCPlus8D, 32'(4 * (i - 1) + 8)); end
        checks++; if (ValidD !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid[%0d]: got %b expected 1", i, ValidD); end
      end
    end
  endtask

  task automatic test_stall_buffer;
    reset_dut();
    tick();
    tick();
    StallD = 1;
    @(negedge clk);
    checks++; if (ImemAddr !== 32'h8) begin errors++; $display("[TB] FAIL stall_fire_addr: got %h expected 8", ImemAddr); end
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      checks++; if (ImemReq !== 1'b0) begin errors++; $display("[TB] FAIL stall_buf_req[%0d]: got %b expected 0", i, ImemReq); end
      checks++; if (InstrD !== word_at(32'h4)) begin errors++; $display("[TB] FAIL stall_hold_instr[%0d]: got %h expected %h", i, InstrD, word_at(32'h4)); end
      checks++; if (ImemAddr !== 32'hC) begin errors++; $display("[TB] FAIL stall_pc_held[%0d]: got %h expected c", i, ImemAddr); end
    end
    tick();
    StallD = 0;
    @(negedge clk);
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("[TB] FAIL unstall_no_fetch: got %b expected 0", ImemReq); end
    tick();
    @(negedge clk);
    checks++; if (InstrD !== word_at(32'h8)) begin errors++; $display("[TB] FAIL unstall_instr: got %h expected %h", InstrD, word_at(32'h8)); end
    checks++; if (PCPlus8D !== 32'h10) begin errors++; $display("[TB] FAIL unstall_pc8: got %h expected 10", PCPlus8D); end
    checks++; if (ValidD !== 1'b1) begin errors++; $display("[TB] FAIL unstall_valid: got %b expected 1", ValidD); end
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'hC) begin errors++; $display("[TB] FAIL unstall_next_req: got req %b addr %h expected req 1 addr c", ImemReq, ImemAddr); end
  endtask

  task automatic test_branch_redirect;
    reset_dut();
    for (int i = 0; i < 4; i++) tick();
    BranchTakenE = 1; BranchTargetE = 32'h100;
    @(negedge clk);
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h10) begin errors++; $display("[TB] FAIL br_fire: got req %b addr %h expected req 1 addr 10", ImemReq, ImemAddr); end
    tick();
    BranchTakenE = 0;
    @(negedge clk);
    checks++; if (ImemAddr !== 32'h100) begin errors++; $display("[TB] FAIL br_target: got %h expected 100", ImemAddr); end
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin errors++; $display("[TB] FAIL br_bubble: got valid %b instr %h expected valid 0 instr 0", ValidD, InstrD); end
    tick();
    @(negedge clk);
    checks++; if (InstrD !== word_at(32'h100)) begin errors++; $display("[TB] FAIL br_first_instr: got %h expected %h", InstrD, word_at(32'h100)); end
    checks++; if (PCPlus8D !== 32'h108) begin errors++; $display("[TB] FAIL br_first_pc8: got %h expected 108", PCPlus8D); end
    checks++; if (ImemAddr !== 32'h104) begin errors++; $display("[TB] FAIL br_next_addr: got %h expected 104", ImemAddr); end
  endtask

  task automatic test_redirect_priority;
    reset_dut();
    PCSrcW = 1; ResultW = 32'h200; BranchTakenE = 1; BranchTargetE = 32'h300;
    tick();
    BranchTakenE = 0;
    @(negedge clk);
    checks++; if (ImemAddr !== 32'h300) begin errors++; $display("[TB] FAIL prio_branch: got %h expected 300", ImemAddr); end
    tick();
    PCSrcW = 0; StallF = 1; BranchTakenE = 1; BranchTargetE = 32'h400;
    @(negedge clk);
    checks++; if (ImemAddr !== 32'h200) begin errors++; $display("[TB] FAIL prio_pcsrc: got %h expected 200", ImemAddr); end
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("[TB] FAIL stallf_req: got %b expected 0", ImemReq); end
    tick();
    StallF = 0; BranchTakenE = 0;
    @(negedge clk);
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h400) begin errors++; $display("[TB] FAIL redirect_over_stallf: got req %b addr %h expected req 1 addr 400", ImemReq, ImemAddr); end
  endtask

  task automatic test_pc_wrap;
    reset_dut();
    BranchTakenE = 1; BranchTargetE = 32'hFFFF_FFFC;
    tick();
    BranchTakenE = 0;
    @(negedge clk);
    checks++; if (ImemAddr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected fffffffc", ImemAddr); end
    tick();
    @(negedge clk);
    checks++; if (ImemAddr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_next: got %h expected 0", ImemAddr); end
    checks++; if (InstrD !== word_at(32'hFFFF_FFFC)) begin errors++; $display("[TB] FAIL wrap_instr: got %h expected %h", InstrD, word_at(32'hFFFF_FFFC)); end
    checks++; if (PCPlus8D !== 32'h4) begin errors++; $display("[TB] FAIL wrap_pc8: got %h expected 4", PCPlus8D); end
  endtask

  task automatic test_ready_wait;
    reset_dut();
    tick();
    ImemReady = 0; StallD = 1;
    @(negedge clk);
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h4) begin errors++; $display("[TB] FAIL wait1: got req %b addr %h expected req 1 addr 4", ImemReq, ImemAddr); end
    checks++; if (InstrD !== word_at(32'h0) || ValidD !== 1'b1) begin errors++; $display("[TB] FAIL wait1_instr: got %h valid %b expected %h valid 1", InstrD, ValidD, word_at(32'h0)); end
    tick();
    FlushD = 1;
    @(negedge clk);
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h4) begin errors++; $display("[TB] FAIL wait2: got req %b addr %h expected req 1 addr 4", ImemReq, ImemAddr); end
    checks++; if (InstrD !== word_at(32'h0) || ValidD !== 1'b1) begin errors++; $display("[TB] FAIL wait2_hold: got %h valid %b expected %h valid 1", InstrD, ValidD, word_at(32'h0)); end
    tick();
    FlushD = 0; StallD = 0;
    @(negedge clk);
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h4) begin errors++; $display("[TB] FAIL wait3: got req %b addr %h expected req 1 addr 4", ImemReq, ImemAddr); end
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus8D !== 32'h0) begin errors++; $display("[TB] FAIL flush_wins: got valid %b instr %h pc8 %h expected all 0", ValidD, InstrD, PCPlus8D); end
    tick();
    @(negedge clk);
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h4) begin errors++; $display("[TB] FAIL wait4: got req %b addr %h expected req 1 addr 4", ImemReq, ImemAddr); end
    tick();
    ImemReady = 1;
    tick();
    @(negedge clk);
    checks++; if (InstrD !== word_at(32'h4) || PCPlus8D !== 32'hC || ValidD !== 1'b1) begin errors++; $display("[TB] FAIL wait_done: got %h pc8 %h valid %b expected %h pc8 c valid 1", InstrD, PCPlus8D, ValidD, word_at(32'h4)); end
    checks++; if (ImemAddr !== 32'h8) begin errors++; $display("[TB] FAIL wait_next_addr: got %h expected 8", ImemAddr); end
  endtask

  task automatic test_reset_midbuffer;
    reset_dut();
    tick();
    StallD = 1;
    tick();
    @(negedge clk);
    checks++; if (ImemReq !== 1'b0 || InstrD !== word_at(32'h0)) begin errors++; $display("[TB] FAIL midbuf_state: got req %b instr %h expected req 0 instr %h", ImemReq, InstrD, word_at(32'h0)); end
    rst_n = 0;
    #1;
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus8D !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_ifid: got valid %b instr %h pc8 %h expected all 0", ValidD, InstrD, PCPlus8D); end
    checks++; if (ImemAddr !== 32'h0 || ImemReq !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_pc: got addr %h req %b expected addr 0 req 0", ImemAddr, ImemReq); end
    StallD = 0;
    tick();
    rst_n = 1;
    @(negedge clk);
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("[TB] FAIL reboot_idle: got %b expected 0", ImemReq); end
    tick();
    @(negedge clk);
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin errors++; $display("[TB] FAIL reboot_fetch: got req %b addr %h expected req 1 addr 0", ImemReq, ImemAddr); end
    tick();
    @(negedge clk);
    checks++; if (InstrD !== word_at(32'h0) || ValidD !== 1'b1) begin errors++; $display("[TB] FAIL reboot_instr: got %h valid %b expected %h valid 1", InstrD, ValidD, word_at(32'h0)); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall_buffer();
    test_branch_redirect();
    test_redirect_priority();
    test_pc_wrap();
    test_ready_wait();
    test_reset_midbuffer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 32-bit ARM-style pipeline.
- Owns PCF and issues requests to instruction memory under a ready handshake.
- Applies branch and PC-write redirects, and holds fetched words across decode stalls in a one-entry skid buffer.
- Drives InstrD and PCPlus8D straight into the decode-stage field splitter.

Parameters:
- BITS, 32, datapath/instruction width
- RESET_PC, 32'h0000_0000, PCF value on reset
- PC_INC, 4, byte increment per sequential fetch

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- StallF  in  1  hazard unit: hold PCF, issue no new request
- StallD  in  1  hazard unit: hold IF/ID register
- FlushD  in  1  hazard unit: bubble IF/ID register
- BranchTakenE  in  1  taken branch resolved in execute
- BranchTargetE  in  BITS  branch target address
- PCSrcW  in  1  writeback stage writes R15
- ResultW  in  BITS  writeback value for R15
- ImemReq  out  1  fetch request valid
- ImemAddr  out  BITS  fetch address (= PCF)
- ImemRData  in  BITS  instruction word, valid when ImemReq & ImemReady
- ImemReady  in  1  memory accepts the request and returns data this cycle
- InstrD  out  BITS  instruction to decode
- PCPlus8D  out  BITS  PC+8 of InstrD (R15 read value)
- ValidD  out  1  InstrD holds a real instruction

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. rst_n=0 forces PCF=RESET_PC, state=BOOT, InstrD=0, PCPlus8D=0, ValidD=0, buffer empty, ImemReq=0.
- BOOT: one idle cycle after reset release, then REQ unconditionally. A redirect in BOOT updates PCF.
- REQ: ImemReq = !StallF and ImemAddr = PCF.
  - Fetch fire = ImemReq & ImemReady.
  - On fire with no redirect: PCF += PC_INC (mod 2^BITS, wrap allowed).
  - Word and PCF+8 go to IF/ID if StallD=0. If StallD=1 they go to the buffer, and the state becomes BUF.
- BUF: ImemReq=0 and PCF is held. When StallD=0, the buffer loads IF/ID, the buffer empties, and the state returns to REQ; no fetch in that cycle.
- Redirect:
  - Redirect = BranchTakenE | PCSrcW. BranchTakenE has priority: next PCF = BranchTargetE, else ResultW.
  - Redirect overrides StallF.
  - A word firing in the same cycle is discarded.
  - A buffered word is discarded and the buffer empties.
  - The state goes to REQ and the first fetch at the new PC is issued next cycle.
- IF/ID register, in priority order:
  - FlushD: InstrD=0, ValidD=0, PCPlus8D=0.
  - Else StallD: hold.
  - Else load the fired word (ValidD=1) or the buffer (ValidD=1). If neither, load a bubble (InstrD=0, ValidD=0).
- Simultaneous FlushD & StallD: flush wins.
- Latency: a request firing in cycle N appears on InstrD in cycle N+1 (ValidD=1) when unstalled.
- ImemReady while ImemReq=0 is ignored. ImemAddr is stable while ImemReq=1 and not ready.
- No combinational path from ImemRData to ImemReq/ImemAddr.

Decomposition:
- Package fetch_pkg holds:
  - typedef enum logic[1:0] {BOOT, REQ, BUF} fetch_state_t
  - localparam NOP_INSTR = 0
  - localparam PC8_OFFSET = 8
- Sub-module fetch_skid_buffer: one-entry instruction/PC holding register with push/pop/clear and a valid flag.

Test Plan:
- Reset release, ImemReady=1 constant, no stalls → ImemAddr 0,4,8,12 from cycle 1. InstrD follows one cycle later with PCPlus8D = addr+8 and ValidD=1.
- StallD=1 for 3 cycles while the word at 0x8 fires → word held in buffer, ImemReq=0. On release, InstrD = word@0x8 and the next request is for 0xC.
- BranchTakenE=1, BranchTargetE=0x100 in the same cycle as a fire at 0x10 → the 0x10 word is dropped, the next ImemAddr is 0x100, and IF/ID shows a bubble.
- PCSrcW=1 (ResultW=0x200) together with BranchTakenE=1 (0x300) → next ImemAddr = 0x300.
- ImemReady low for 4 cycles → ImemAddr is held and ImemReq stays high. FlushD during the wait forces ValidD=0 and InstrD=0.
- rst_n asserted with a buffered word → all outputs return to reset values immediately; BOOT then fetches RESET_PC.
